pwm_multi_ch: RTL and testbench

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_ch.sv | 44 ++++
 rtl/pwm_multi_ch.sv | 173 +++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
// Center-aligned counting is compiled in only when PWM_CENTER_EN is defined.
package pwm_pkg;

    typedef enum logic {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTER = 1'b1
    } pwm_mode_e;

    localparam int PWM_DEF_WIDTH = 8;
    localparam int PWM_DEF_NCH   = 4;

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: compares the shared counter against this channel's
// set/clear thresholds and keeps the registered output level.
// Clear always has priority over set in the same cycle.
module pwm_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             res_ni,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             set_ok_i,
    input  logic             clr_ok_i,
    input  logic [WIDTH-1:0] set_thres_i,
    input  logic [WIDTH-1:0] clr_thres_i,
    output logic             pwm_o
);

    logic pwm_q;
    logic pwm_d;

    // Decide the next output level from the current count
    always_comb begin
        pwm_d = pwm_q;
        if (clr_ok_i && (cnt_i == clr_thres_i)) begin
            pwm_d = 1'b0;
        end else if (set_ok_i && (cnt_i == set_thres_i)) begin
            pwm_d = 1'b1;
        end
    end

    // Output register, frozen while the block is disabled
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            pwm_q <= 1'b0;
        end else if (ena_i) begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared period counter, shadowed configuration that is
// committed only at a period end (glitch-free updates), and NCH channel
// compare stages. Define PWM_CENTER_EN to compile in center-aligned counting;
// otherwise mode_i is ignored and edge counting always applies.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEF_WIDTH,
    parameter int NCH   = PWM_DEF_NCH
) (
    input  logic                 clk,
    input  logic                 res_ni,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     period_i,
    input  logic [NCH*WIDTH-1:0] set_thres_i,
    input  logic [NCH*WIDTH-1:0] clr_thres_i,
    input  logic                 mode_i,
    input  logic                 load_i,
    output logic                 pending_o,
    output logic                 period_end_o,
    output logic [WIDTH-1:0]     cnt_o,
    output logic [NCH-1:0]       pwm_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]     cnt_q;
    logic [WIDTH-1:0]     cnt_d;
    logic [WIDTH-1:0]     sh_period_q;
    logic [WIDTH-1:0]     act_period_q;
    logic [NCH*WIDTH-1:0] sh_set_q;
    logic [NCH*WIDTH-1:0] sh_clr_q;
    logic [NCH*WIDTH-1:0] act_set_q;
    logic [NCH*WIDTH-1:0] act_clr_q;
    logic                 pending_q;
    logic                 commit;
    logic                 load_acc;
    logic                 set_ok;
    logic                 clr_ok;

`ifdef PWM_CENTER_EN
    pwm_mode_e sh_mode_q;
    pwm_mode_e act_mode_q;
    logic      dir_down_q;
    logic      dir_down_d;

    // Next count and direction; direction marks the state of the count it
    // accompanies, so the top count P is already "down" and 0 is "up"
    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        if (act_period_q == '0) begin
            cnt_d = '0;
        end else if (act_mode_q == PWM_MODE_EDGE) begin
            cnt_d = (cnt_q >= act_period_q) ? '0 : cnt_q + ONE;
        end else if (dir_down_q) begin
            cnt_d = (cnt_q == '0) ? ONE : cnt_q - ONE;
        end else begin
            cnt_d = (cnt_q >= act_period_q) ? cnt_q - ONE : cnt_q + ONE;
        end
        if (cnt_d == '0) begin
            dir_down_d = 1'b0;
        end else if ((act_mode_q == PWM_MODE_CENTER) && (cnt_d == act_period_q)) begin
            dir_down_d = 1'b1;
        end
    end

    // Direction register; reaching 0 (every commit) forces it back to up
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            dir_down_q <= 1'b0;
        end else if (ena) begin
            dir_down_q <= dir_down_d;
        end
    end

    // Mode follows the same shadow/active path as the other settings
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            sh_mode_q  <= PWM_MODE_EDGE;
            act_mode_q <= PWM_MODE_EDGE;
        end else begin
            if (commit) begin
                act_mode_q <= sh_mode_q;
            end
            if (load_acc) begin
                sh_mode_q <= pwm_mode_e'(mode_i);
            end
        end
    end

    assign set_ok = (act_mode_q == PWM_MODE_EDGE) || !dir_down_q;
    assign clr_ok = (act_mode_q == PWM_MODE_EDGE) || dir_down_q;
`else
    logic unused_mode;

    // Edge counting only: 0..P then wrap
    always_comb begin
        cnt_d = '0;
        if ((act_period_q != '0) && (cnt_q < act_period_q)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    assign set_ok      = 1'b1;
    assign clr_ok      = 1'b1;
    assign unused_mode = mode_i;
`endif

    assign load_acc     = ena && load_i;
    assign period_end_o = ena && (cnt_d == '0);
    assign commit       = period_end_o && pending_q;

    // Shared counter, frozen while disabled
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            cnt_q <= '0;
        end else if (ena) begin
            cnt_q <= cnt_d;
        end
    end

    // Shadow capture, active commit and pending flag; a load in the commit
    // cycle commits the old shadow and keeps the new one pending
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            sh_period_q  <= '0;
            sh_set_q     <= '0;
            sh_clr_q     <= '0;
            act_period_q <= '0;
            act_set_q    <= '0;
            act_clr_q    <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (commit) begin
                act_period_q <= sh_period_q;
                act_set_q    <= sh_set_q;
                act_clr_q    <= sh_clr_q;
            end
            if (load_acc) begin
                sh_period_q <= period_i;
                sh_set_q    <= set_thres_i;
                sh_clr_q    <= clr_thres_i;
                pending_q   <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            pwm_ch #(
                .WIDTH(WIDTH)
            ) u_ch (
                .clk        (clk),
                .res_ni     (res_ni),
                .ena_i      (ena),
                .cnt_i      (cnt_q),
                .set_ok_i   (set_ok),
                .clr_ok_i   (clr_ok),
                .set_thres_i(act_set_q[gi*WIDTH +: WIDTH]),
                .clr_thres_i(act_clr_q[gi*WIDTH +: WIDTH]),
                .pwm_o      (pwm_o[gi])
            );
        end
    endgenerate

    assign pending_o = pending_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Testbench for pwm_multi_ch: phase-based behavioural model checked every
// cycle, plus directed literal checks. Center-mode cases run only when
// PWM_CENTER_EN is defined.
module tb_pwm_multi_ch;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic                 clk = 1'b0;
    logic                 res_ni = 1'b1;
    logic                 ena = 1'b0;
    logic [WIDTH-1:0]     period_v = '0;
    logic [NCH*WIDTH-1:0] set_v = '0;
    logic [NCH*WIDTH-1:0] clr_v = '0;
    logic                 mode_v = 1'b0;
    logic                 load_v = 1'b0;
    logic                 pending_o;
    logic                 period_end_o;
    logic [WIDTH-1:0]     cnt_o;
    logic [NCH-1:0]       pwm_o;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    pwm_multi_ch #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk         (clk),
        .res_ni      (res_ni),
        .ena         (ena),
        .period_i    (period_v),
        .set_thres_i (set_v),
        .clr_thres_i (clr_v),
        .mode_i      (mode_v),
        .load_i      (load_v),
        .pending_o   (pending_o),
        .period_end_o(period_end_o),
        .cnt_o       (cnt_o),
        .pwm_o       (pwm_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (period phase based) ----------------
    int             m_phase, m_p, sh_p;
    int             m_set[NCH], m_clr[NCH], sh_set[NCH], sh_clr[NCH];
    bit             m_ctr, sh_ctr, m_pending;
    logic [NCH-1:0] m_pwm;

    function automatic int len_of(int p, bit ctr);
        if (p == 0) return 1;
        return ctr ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_of(int ph, int p, bit ctr);
        if (ctr && ph > p) return 2 * p - ph;
        return ph;
    endfunction

    function automatic bit down_of(int ph, int p, bit ctr);
        return ctr && (p != 0) && (ph >= p);
    endfunction

    always @(posedge clk or negedge res_ni) begin
        int             cur;
        bit             dn;
        bit             at_end;
        logic [NCH-1:0] np;
        if (!res_ni) begin
            m_phase   <= 0;
            m_p       <= 0;
            sh_p      <= 0;
            m_ctr     <= 1'b0;
            sh_ctr    <= 1'b0;
            m_pending <= 1'b0;
            m_pwm     <= '0;
            for (int c = 0; c < NCH; c++) begin
                m_set[c] <= 0; m_clr[c] <= 0; sh_set[c] <= 0; sh_clr[c] <= 0;
            end
        end else if (ena) begin
            cur    = cnt_of(m_phase, m_p, m_ctr);
            dn     = down_of(m_phase, m_p, m_ctr);
            at_end = (m_phase == len_of(m_p, m_ctr) - 1);
            np     = m_pwm;
            for (int c = 0; c < NCH; c++) begin
                if (cur == m_clr[c] && (!m_ctr || dn)) np[c] = 1'b0;
                else if (cur == m_set[c] && (!m_ctr || !dn)) np[c] = 1'b1;
            end
            m_pwm   <= np;
            m_phase <= at_end ? 0 : m_phase + 1;
            if (at_end && m_pending) begin
                m_p   <= sh_p;
                m_ctr <= sh_ctr;
                for (int c = 0; c < NCH; c++) begin
                    m_set[c] <= sh_set[c]; m_clr[c] <= sh_clr[c];
                end
            end
            if (load_v) begin
                m_pending <= 1'b1;
                sh_p      <= int'(period_v);
`ifdef PWM_CENTER_EN
                sh_ctr    <= mode_v;
`else
                sh_ctr    <= 1'b0;
`endif
                for (int c = 0; c < NCH; c++) begin
                    sh_set[c] <= int'(set_v[c*WIDTH +: WIDTH]);
                    sh_clr[c] <= int'(clr_v[c*WIDTH +: WIDTH]);
                end
            end else if (at_end) begin
                m_pending <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        int   exp_cnt;
        logic exp_pe;
        if (chk_en) begin
            exp_cnt = cnt_of(m_phase, m_p, m_ctr);
            exp_pe  = ena && (m_phase == len_of(m_p, m_ctr) - 1);
            vectors++;
            if (int'(cnt_o) != exp_cnt || pwm_o !== m_pwm || pending_o !== m_pending ||
                period_end_o !== exp_pe) begin
                miscompares++;
                $display("FAIL cycle t=%0t: cnt %0d want %0d, pwm %b want %b, pending %b want %b, period_end %b want %b",
                         $time, cnt_o, exp_cnt, pwm_o, m_pwm, pending_o, m_pending, period_end_o, exp_pe);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg();
        int p;
        p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
        period_v = WIDTH'(p);
        for (int c = 0; c < NCH; c++) begin
            set_v[c*WIDTH +: WIDTH] = WIDTH'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, p + 2));
            clr_v[c*WIDTH +: WIDTH] = WIDTH'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, p + 2));
        end
        mode_v = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi0, hi1, pe_n, guard;
        #1 res_ni = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check("rst_cnt", 32'(cnt_o), 0);
        check("rst_pwm", 32'(pwm_o), 0);
        check("rst_pending", 32'(pending_o), 0);
        res_ni = 1'b1;
        ena    = 1'b1;
        tick();
        check("p0_period_end", 32'(period_end_o), 1);

        // Edge: P=9, ch0 set 2 / clr 7, ch1 set=clr=4
        period_v = 8'd9;
        set_v = {8'd50, 8'd60, 8'd4, 8'd2};
        clr_v = {8'd51, 8'd61, 8'd4, 8'd7};
        load_v = 1'b1; tick(); load_v = 1'b0;
        check("load_pending", 32'(pending_o), 1);
        tick();
        check("commit_cnt0", 32'(cnt_o), 0);
        check("commit_pending", 32'(pending_o), 0);
        hi0 = 0; hi1 = 0; pe_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hi0 += int'(pwm_o[0]); hi1 += int'(pwm_o[1]); pe_n += int'(period_end_o);
        end
        check("edge_ch0_high", 32'(hi0), 10);
        check("clr_prio_ch1", 32'(hi1), 0);
        check("edge_period_ends", 32'(pe_n), 2);

        // Mid-period update of clr0 to 5
        tick(5);
        check("mid_cnt4", 32'(cnt_o), 4);
        clr_v[7:0] = 8'd5;
        load_v = 1'b1; tick(); load_v = 1'b0;
        check("mid_pending", 32'(pending_o), 1);
        tick();
        check("old_wave_cnt6", 32'(pwm_o[0]), 1);
        tick(3);
        check("mid_pe_cnt9", 32'(period_end_o), 1);
        tick();
        check("mid_pending_fall", 32'(pending_o), 0);
        tick(6);
        check("new_wave_cnt6", 32'(pwm_o[0]), 0);

        // ena low 3 cycles with an ignored load
        ena = 1'b0; load_v = 1'b1; period_v = 8'd3;
        tick(3);
        check("frz_cnt", 32'(cnt_o), 6);
        check("frz_pe", 32'(period_end_o), 0);
        check("frz_pending", 32'(pending_o), 0);
        ena = 1'b1; load_v = 1'b0; period_v = 8'd9;
        tick(3);
        check("frz_resume_pe", 32'(period_end_o), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ena    = ($urandom_range(0, 9) != 0);
            load_v = ($urandom_range(0, 19) == 0);
            if (load_v) rand_cfg();
            tick();
        end
        ena = 1'b1; load_v = 1'b0;

`ifdef PWM_CENTER_EN
        // Center: P=4, set=clr=2
        period_v = 8'd4; mode_v = 1'b1;
        set_v = {8'd9, 8'd9, 8'd9, 8'd2};
        clr_v = {8'd9, 8'd9, 8'd9, 8'd2};
        load_v = 1'b1; tick(); load_v = 1'b0;
        guard = 0;
        while (pending_o && guard < 600) begin tick(); guard++; end
        check("ctr_commit_wait", 32'(pending_o), 0);
        check("ctr_cnt0", 32'(cnt_o), 0);
        hi0 = 0; pe_n = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hi0 += int'(pwm_o[0]); pe_n += int'(period_end_o);
            if (period_end_o) check("ctr_pe_at_cnt1", 32'(cnt_o), 1);
        end
        check("ctr_ch0_high", 32'(hi0), 4);
        check("ctr_period_ends", 32'(pe_n), 1);
        tick();
`endif

        // Reset with a pending shadow
        period_v = 8'd200;
        set_v = {8'd1, 8'd1, 8'd1, 8'd1};
        clr_v = {8'd150, 8'd150, 8'd150, 8'd150};
        load_v = 1'b1; tick(); load_v = 1'b0;
        check("pre_rst_pending", 32'(pending_o), 1);
        #2 res_ni = 1'b0;
        #1;
        check("async_rst_cnt", 32'(cnt_o), 0);
        check("async_rst_pwm", 32'(pwm_o), 0);
        check("async_rst_pending", 32'(pending_o), 0);
        tick(2);
        res_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_pwm", 32'(pwm_o), 0);
            check("post_rst_pe", 32'(period_end_o), 1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
